// File: rtl/isp_csc_arb.sv
// Frame-granular two-requester arbiter sharing one isp_csc instance.
// Input grant is locked for a full frame; gray outputs route back to the owner until the frame drains.
module isp_csc_arb #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int DATA_WIDTH = 24,
  parameter int CNT_W      = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid_m,
  input  logic [DATA_WIDTH-1:0] req0_data_m_rgb,
  output logic                  req0_ready_m,
  input  logic                  req1_valid_m,
  input  logic [DATA_WIDTH-1:0] req1_data_m_rgb,
  output logic                  req1_ready_m,
  output logic                  csc_valid_m,
  output logic [DATA_WIDTH-1:0] csc_data_m_rgb,
  input  logic                  csc_ready_m,
  input  logic                  csc_valid_s,
  input  logic [7:0]            csc_data_s_gray,
  output logic                  csc_ready_s,
  output logic                  out0_valid_s,
  output logic [7:0]            out0_data_s_gray,
  input  logic                  out0_ready_s,
  output logic                  out1_valid_s,
  output logic [7:0]            out1_data_s_gray,
  input  logic                  out1_ready_s,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_id
);

  localparam int unsigned TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt, last_owner;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             in_hs, out_hs, in_last, out_last, start;
  logic             in_open, out_open;

  assign in_hs    = csc_valid_m & csc_ready_m;
  assign out_hs   = csc_valid_s & csc_ready_s;
  assign in_last  = in_hs && (in_cnt == LAST);
  assign out_last = out_hs && (out_cnt == LAST);
  assign start    = req0_valid_m | req1_valid_m;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    owner_nxt = 1'b0;
    if (req0_valid_m && req1_valid_m) owner_nxt = ~last_owner;
    else if (req1_valid_m)            owner_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Output-side completion wins over input-side completion in GRANT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = GRANT;
      GRANT: begin
        if (out_last)     state_nxt = IDLE;
        else if (in_last) state_nxt = DRAIN;
      end
      DRAIN:   if (out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
      frame_id   <= 1'b0;
    end else begin
      frame_done <= out_last;
      if (state == IDLE && start) owner <= owner_nxt;
      if (out_last) begin
        in_cnt     <= '0;
        out_cnt    <= '0;
        frame_id   <= owner;
        last_owner <= owner;
      end else begin
        if (state == GRANT && in_hs) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
        if (out_hs)                  out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    in_open          = (state == GRANT);
    out_open         = (state != IDLE);
    busy             = out_open;
    grant            = out_open ? (owner ? 2'b10 : 2'b01) : 2'b00;
    csc_valid_m      = in_open & (owner ? req1_valid_m : req0_valid_m);
    csc_data_m_rgb   = in_open ? (owner ? req1_data_m_rgb : req0_data_m_rgb) : '0;
    req0_ready_m     = in_open & ~owner & csc_ready_m;
    req1_ready_m     = in_open &  owner & csc_ready_m;
    csc_ready_s      = out_open & (owner ? out1_ready_s : out0_ready_s);
    out0_valid_s     = out_open & ~owner & csc_valid_s;
    out1_valid_s     = out_open &  owner & csc_valid_s;
    out0_data_s_gray = (out_open & ~owner) ? csc_data_s_gray : '0;
    out1_data_s_gray = (out_open &  owner) ? csc_data_s_gray : '0;
  end

endmodule

// File: tb/tb_isp_csc_arb.sv
// Scoreboard bench for isp_csc_arb with a 4x2 frame and a 2-cycle-latency csc model.
module tb_isp_csc_arb;
  localparam int W = 4, H = 2, DW = 24, CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid_m, req1_valid_m, req0_ready_m, req1_ready_m;
  logic [DW-1:0] req0_data_m_rgb, req1_data_m_rgb, csc_data_m_rgb;
  logic          csc_valid_m, csc_ready_m, csc_valid_s, csc_ready_s;
  logic [7:0]    csc_data_s_gray, out0_data_s_gray, out1_data_s_gray;
  logic          out0_valid_s, out0_ready_s, out1_valid_s, out1_ready_s;
  logic [1:0]    grant;
  logic          busy, frame_done, frame_id;

  isp_csc_arb #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_m(req0_valid_m), .req0_data_m_rgb(req0_data_m_rgb), .req0_ready_m(req0_ready_m),
    .req1_valid_m(req1_valid_m), .req1_data_m_rgb(req1_data_m_rgb), .req1_ready_m(req1_ready_m),
    .csc_valid_m(csc_valid_m), .csc_data_m_rgb(csc_data_m_rgb), .csc_ready_m(csc_ready_m),
    .csc_valid_s(csc_valid_s), .csc_data_s_gray(csc_data_s_gray), .csc_ready_s(csc_ready_s),
    .out0_valid_s(out0_valid_s), .out0_data_s_gray(out0_data_s_gray), .out0_ready_s(out0_ready_s),
    .out1_valid_s(out1_valid_s), .out1_data_s_gray(out1_data_s_gray), .out1_ready_s(out1_ready_s),
    .grant(grant), .busy(busy), .frame_done(frame_done), .frame_id(frame_id)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int left[2], idx[2], sent[2];
  int cyc = 0;
  bit rnd_sink0 = 0, rnd_csc = 0;
  int n_out0 = 0, n_out1 = 0, f_out0 = 0, f_out1 = 0, fd_cnt = 0, viol = 0;

  typedef struct { logic [7:0] g; int t; } csc_ent_t;
  csc_ent_t   cq[$];
  logic [7:0] exp0[$], exp1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int s, input int k);
    return {8'(s * 100 + k * 7), 8'(k * 13 + 5), 8'(250 - k * 3)};
  endfunction

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    logic [9:0] sum;
    sum = {2'b0, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b0, p[7:0]};
    return sum[9:2];
  endfunction

  // Sources, csc model and expected-value producer; inputs change on negedge only.
  initial begin
    left = '{0, 0}; idx = '{0, 0}; sent = '{0, 0};
    req0_valid_m = 0; req1_valid_m = 0; req0_data_m_rgb = '0; req1_data_m_rgb = '0;
    csc_ready_m = 0; csc_valid_s = 0; csc_data_s_gray = '0; out0_ready_s = 0; out1_ready_s = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin cq.delete(); exp0.delete(); exp1.delete(); end
      req0_valid_m    = rst_n && left[0] > 0;
      req1_valid_m    = rst_n && left[1] > 0;
      req0_data_m_rgb = pix(0, idx[0]);
      req1_data_m_rgb = pix(1, idx[1]);
      csc_ready_m     = rst_n && cq.size() < 4 && (!rnd_csc || $urandom_range(1, 0) == 1);
      csc_valid_s     = rst_n && cq.size() > 0 && cq[0].t <= cyc;
      csc_data_s_gray = csc_valid_s ? cq[0].g : 8'h00;
      out0_ready_s    = !rnd_sink0 || $urandom_range(1, 0) == 1;
      out1_ready_s    = 1'b1;
      #1;
      if (rst_n) begin
        if (req0_valid_m && req0_ready_m) begin
          exp0.push_back(gray_of(req0_data_m_rgb)); idx[0]++; left[0]--; sent[0]++;
        end
        if (req1_valid_m && req1_ready_m) begin
          exp1.push_back(gray_of(req1_data_m_rgb)); idx[1]++; left[1]--; sent[1]++;
        end
        if (csc_valid_s && csc_ready_s) cq.delete(0);
        if (csc_valid_m && csc_ready_m) cq.push_back('{gray_of(csc_data_m_rgb), cyc + 2});
      end
    end
  end

  // Monitor: pops the scoreboard on every sink handshake.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        if (out0_valid_s && out0_ready_s) begin
          n_out0++; f_out0++;
          if (exp0.size() == 0) begin
            checks++; errors++;
            $display("FAIL out0_extra: got %0h expected none", out0_data_s_gray);
          end else begin
            e = exp0.pop_front();
            check("out0_data", {24'b0, out0_data_s_gray}, {24'b0, e});
          end
        end
        if (out1_valid_s && out1_ready_s) begin
          n_out1++; f_out1++;
          if (exp1.size() == 0) begin
            checks++; errors++;
            $display("FAIL out1_extra: got %0h expected none", out1_data_s_gray);
          end else begin
            e = exp1.pop_front();
            check("out1_data", {24'b0, out1_data_s_gray}, {24'b0, e});
          end
        end
        if ((req0_ready_m && grant != 2'b01) || (req1_ready_m && grant != 2'b10) ||
            (out0_valid_s && grant != 2'b01) || (out1_valid_s && grant != 2'b10) ||
            (csc_ready_s && grant == 2'b00))
          viol++;
        if (frame_done) fd_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #3;
  endtask

  task automatic do_reset();
    rst_n = 0; left = '{0, 0};
    tick(); tick();
    rst_n = 1; f_out0 = 0; f_out1 = 0;
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin tick(); n++; end while (!frame_done && n < 200);
    if (!frame_done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got frame_done=0 expected 1", name);
    end
  endtask

  task automatic check_frame(input string name, input int id);
    check({name, "_frame_done"}, 32'(frame_done), 1);
    check({name, "_frame_id"}, 32'(frame_id), 32'(id));
    check({name, "_idle_grant"}, 32'(grant), 0);
    check({name, "_idle_busy"}, 32'(busy), 0);
    check({name, "_owner_count"}, id == 1 ? f_out1 : f_out0, 8);
    check({name, "_other_count"}, id == 1 ? f_out0 : f_out1, 0);
    f_out0 = 0; f_out1 = 0;
  endtask

  initial begin
    int n, gap, leak, base;
    rst_n = 0;

    // 1: reset state, single source
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_id", 32'(frame_id), 0);
    check("rst_readys", {28'b0, req0_ready_m, req1_ready_m, csc_ready_s, csc_valid_m}, 0);
    check("rst_out_valid", {30'b0, out0_valid_s, out1_valid_s}, 0);
    check("rst_data", {csc_data_m_rgb, out0_data_s_gray | out1_data_s_gray}, 0);
    left[0] = 8;
    tick();
    check("s1_arb_grant", 32'(grant), 0);
    check("s1_arb_ready", 32'(req0_ready_m), 0);
    tick();
    check("s1_grant", 32'(grant), 32'h1);
    check("s1_busy", 32'(busy), 1);
    wait_fd("s1");
    check_frame("s1", 0);
    tick();
    check("s1_pulse_end", 32'(frame_done), 0);
    check("s1_out1_none", n_out1, 0);

    // 2: both valid from reset, req0 first
    do_reset();
    left = '{8, 8};
    tick(); tick();
    check("s2_grant0", 32'(grant), 32'h1);
    wait_fd("s2a");
    check_frame("s2a", 0);
    tick();
    check("s2_grant1", 32'(grant), 32'h2);
    wait_fd("s2b");
    check_frame("s2b", 1);

    // 3: four back-to-back frames alternate owners
    do_reset();
    left = '{16, 16};
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("s3_grant", 32'(grant), (i % 2 == 1) ? 32'h2 : 32'h1);
      wait_fd("s3");
      check_frame("s3", i % 2);
      tick();
    end
    check("s3_final_grant", 32'(grant), 0);

    // 4: random sink0 and csc backpressure; busy must hold until the 8th output
    do_reset();
    rnd_sink0 = 1; rnd_csc = 1;
    left[0] = 8;
    tick(); tick();
    check("s4_grant", 32'(grant), 32'h1);
    gap = 0; n = 0;
    do begin
      tick(); n++;
      if (!busy && !frame_done) gap++;
    end while (!frame_done && n < 400);
    check("s4_frame_seen", 32'(frame_done), 1);
    check("s4_busy_gap", gap, 0);
    check_frame("s4", 0);
    check("s4_exp_empty", exp0.size(), 0);
    rnd_sink0 = 0; rnd_csc = 0;

    // 5: req1 raised during req0 frame stays blocked until handover
    do_reset();
    left[0] = 8;
    tick();
    left[1] = 8;
    leak = 0; n = 0;
    do begin
      tick(); n++;
      if (req1_ready_m) leak++;
    end while (!frame_done && n < 200);
    check("s5_req1_blocked", leak, 0);
    check_frame("s5a", 0);
    tick();
    check("s5_handover", 32'(grant), 32'h2);
    wait_fd("s5b");
    check_frame("s5b", 1);

    // 6: reset after the 3rd input pixel, then a clean frame
    do_reset();
    left[0] = 8;
    base = sent[0]; n = 0;
    while (sent[0] - base < 3 && n < 100) begin tick(); n++; end
    tick();
    rst_n = 0; left[0] = 0;
    tick();
    rst_n = 1;
    check("s6_grant", 32'(grant), 0);
    check("s6_busy", 32'(busy), 0);
    check("s6_in_cnt", 32'(dut.in_cnt), 0);
    check("s6_out_cnt", 32'(dut.out_cnt), 0);
    f_out0 = 0; f_out1 = 0;
    left[0] = 8;
    tick(); tick();
    check("s6_regrant", 32'(grant), 32'h1);
    wait_fd("s6");
    check_frame("s6", 0);

    tick(); tick();
    check("protocol_violations", viol, 0);
    check("exp0_drained", exp0.size(), 0);
    check("exp1_drained", exp1.size(), 0);
    check("frame_done_total", fd_cnt, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
